rs_issue_scheduler: RTL and testbench

Oldest-first issue scheduler for the reservation station. It tracks allocation age, selects one ready entry per cycle whose functional unit can accept work, and presents it downstream on a valid/ready handshake. On handoff it returns a one-hot `free` pulse to the station. It also owns occupancy of the non-pipelined multiplier units.

---
 rtl/rs_issue_scheduler_if.sv | 36 +++
 rtl/rs_issue_scheduler.sv | 142 ++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_issue_scheduler_if.sv
// Scheduler-side bundle: entry status and allocation from the reservation station,
// and the issue handshake, free pulse and multiplier occupancy going back out.
interface rs_issue_scheduler_if #(
  parameter int NUM_ENTRIES = 5,
  parameter int NUM_MULT    = 2
);
  localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int MW = (NUM_MULT > 1) ? $clog2(NUM_MULT) : 1;

  logic                     alloc_valid;
  logic [IW-1:0]            alloc_index;
  logic [NUM_ENTRIES-1:0]   entry_valid;
  logic [NUM_ENTRIES-1:0]   entry_ready;
  logic [2*NUM_ENTRIES-1:0] entry_fu;
  logic                     mem_busy;
  logic                     flush;
  logic                     issue_ready;
  logic                     issue_valid;
  logic [NUM_ENTRIES-1:0]   issue_onehot;
  logic [1:0]               issue_fu;
  logic [MW-1:0]            issue_mult_unit;
  logic [NUM_ENTRIES-1:0]   free;
  logic [NUM_MULT-1:0]      mult_busy;

  modport master (
    output alloc_valid, alloc_index, entry_valid, entry_ready, entry_fu,
           mem_busy, flush, issue_ready,
    input  issue_valid, issue_onehot, issue_fu, issue_mult_unit, free, mult_busy
  );

  modport slave (
    input  alloc_valid, alloc_index, entry_valid, entry_ready, entry_fu,
           mem_busy, flush, issue_ready,
    output issue_valid, issue_onehot, issue_fu, issue_mult_unit, free, mult_busy
  );
endinterface

// File: rtl/rs_issue_scheduler.sv
// Oldest-first issue scheduler: age matrix, pending mask, one-entry issue register
// with valid/ready handoff, free pulse and non-pipelined multiplier occupancy.
module rs_issue_scheduler #(
  parameter int NUM_ENTRIES  = 5,
  parameter int NUM_MULT     = 2,
  parameter int MULT_LATENCY = 4
) (
  input logic                 clock,
  input logic                 reset,
  rs_issue_scheduler_if.slave bus
);
  localparam int N  = NUM_ENTRIES;
  localparam int MW = (NUM_MULT > 1) ? $clog2(NUM_MULT) : 1;
  localparam int CW = $clog2(MULT_LATENCY + 1);
  localparam logic [1:0] FU_ALU = 2'd0, FU_LOAD = 2'd1, FU_STORE = 2'd2, FU_MULT = 2'd3;

  logic [N-1:0]        older [N];
  logic [N-1:0]        older_col [N];
  logic [N-1:0]        pending;
  logic [CW-1:0]       mult_cnt [NUM_MULT];
  logic                issue_valid;
  logic [N-1:0]        issue_onehot;
  logic [1:0]          issue_fu;
  logic [MW-1:0]       issue_mult_unit;
  logic [N-1:0]        free;
  logic [NUM_MULT-1:0] reserved, mult_busy;
  logic [N-1:0]        eligible, cand, pick;
  logic [1:0]          pick_fu;
  logic [MW-1:0]       idle_unit;
  logic                fire, can_load, has_pick, mult_idle;

  function automatic logic fu_ok(input logic [1:0] fu, input logic mem_busy,
                                 input logic any_idle);
    case (fu)
      FU_ALU:            fu_ok = 1'b1;
      FU_LOAD, FU_STORE: fu_ok = ~mem_busy;
      default:           fu_ok = any_idle;
    endcase
  endfunction

  assign fire     = issue_valid & bus.issue_ready;
  assign can_load = ~issue_valid | bus.issue_ready;

  // A unit is held either by its post-fire countdown or by the presented issue.
  always_comb begin
    idle_unit = '0;
    for (int u = 0; u < NUM_MULT; u++) begin
      reserved[u]  = issue_valid && (issue_fu == FU_MULT) && (issue_mult_unit == MW'(u));
      mult_busy[u] = (mult_cnt[u] != '0) || reserved[u];
    end
    for (int u = NUM_MULT - 1; u >= 0; u--)
      if (!mult_busy[u]) idle_unit = MW'(u);
  end

  assign mult_idle = ~&mult_busy;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = bus.entry_valid[i] & bus.entry_ready[i] & ~pending[i] &
                    fu_ok(bus.entry_fu[2*i +: 2], bus.mem_busy, mult_idle);
      for (int j = 0; j < N; j++) older_col[i][j] = older[j][i];
    end
  end

  // Oldest eligible: nothing eligible is older; ties resolve to the lowest index.
  always_comb begin
    cand    = '0;
    pick    = '0;
    pick_fu = FU_ALU;
    for (int i = 0; i < N; i++) cand[i] = eligible[i] & ~|(eligible & older_col[i]);
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
        pick_fu = bus.entry_fu[2*i +: 2];
      end
    end
  end

  assign has_pick = |pick;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_valid     <= 1'b0;
      issue_onehot    <= '0;
      issue_fu        <= FU_ALU;
      issue_mult_unit <= '0;
      free            <= '0;
      pending         <= '0;
      for (int i = 0; i < N; i++) older[i] <= '0;
      for (int u = 0; u < NUM_MULT; u++) mult_cnt[u] <= '0;
    end else if (bus.flush) begin
      issue_valid     <= 1'b0;
      issue_onehot    <= '0;
      issue_fu        <= FU_ALU;
      issue_mult_unit <= '0;
      free            <= '0;
      pending         <= '0;
      for (int i = 0; i < N; i++) older[i] <= '0;
      for (int u = 0; u < NUM_MULT; u++) mult_cnt[u] <= '0;
    end else begin
      free <= fire ? issue_onehot : '0;
      for (int u = 0; u < NUM_MULT; u++) begin
        if (fire && reserved[u])    mult_cnt[u] <= CW'(MULT_LATENCY);
        else if (mult_cnt[u] != '0) mult_cnt[u] <= mult_cnt[u] - CW'(1);
      end
      if (can_load) begin
        issue_valid     <= has_pick;
        issue_onehot    <= pick;
        issue_fu        <= has_pick ? pick_fu : FU_ALU;
        issue_mult_unit <= (has_pick && pick_fu == FU_MULT) ? idle_unit : '0;
      end
      for (int i = 0; i < N; i++) begin
        if (bus.alloc_valid && (bus.alloc_index == i[$bits(bus.alloc_index)-1:0]))
          pending[i] <= 1'b0;
        else
          pending[i] <= (pending[i] | (can_load & pick[i])) & bus.entry_valid[i];
      end
      // The allocated entry becomes younger than every live entry.
      if (bus.alloc_valid) begin
        for (int k = 0; k < N; k++) begin
          if (bus.alloc_index == k[$bits(bus.alloc_index)-1:0]) begin
            for (int i = 0; i < N; i++) begin
              if (i != k) begin
                older[i][k] <= bus.entry_valid[i];
                older[k][i] <= 1'b0;
              end
            end
          end
        end
      end
    end
  end

  assign bus.issue_valid     = issue_valid;
  assign bus.issue_onehot    = issue_onehot;
  assign bus.issue_fu        = issue_fu;
  assign bus.issue_mult_unit = issue_mult_unit;
  assign bus.free            = free;
  assign bus.mult_busy       = mult_busy;
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Bench for rs_issue_scheduler: the bench plays the reservation station and keeps a
// queue of expected issues, popped whenever a handoff occurs.
module tb_rs_issue_scheduler;
  localparam int N   = 5;
  localparam int NM  = 2;
  localparam int LAT = 4;
  localparam logic [1:0] ALU = 2'd0, LOAD = 2'd1, STORE = 2'd2, MULT = 2'd3;

  typedef struct packed {
    logic [N-1:0] oh;
    logic [1:0]   fu;
    logic         mu;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  logic         fired;
  logic [N-1:0] fired_oh;
  logic [1:0]   fired_fu;
  logic         fired_mu;

  rs_issue_scheduler_if #(.NUM_ENTRIES(N), .NUM_MULT(NM)) bus();

  rs_issue_scheduler #(.NUM_ENTRIES(N), .NUM_MULT(NM), .MULT_LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (!reset && bus.alloc_valid && !bus.flush)
      assert (!(bus.entry_valid[bus.alloc_index] && !bus.free[bus.alloc_index]))
        else $error("illegal alloc to live entry %0d", bus.alloc_index);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Capture the handoff that the next edge performs, cross it, then act as the
  // station by dropping any entry the scheduler just freed.
  task automatic tick();
    fired    = bus.issue_valid & bus.issue_ready;
    fired_oh = bus.issue_onehot;
    fired_fu = bus.issue_fu;
    fired_mu = bus.issue_mult_unit;
    @(posedge clock);
    #1;
    bus.entry_valid = bus.entry_valid & ~bus.free;
  endtask

  task automatic alloc(input int k, input logic [1:0] fu);
    bus.alloc_valid          = 1'b1;
    bus.alloc_index          = 3'(k);
    bus.entry_fu[2*k +: 2]   = fu;
    tick();
    bus.alloc_valid          = 1'b0;
    bus.entry_valid[k]       = 1'b1;
  endtask

  task automatic test_reset();
    bus.alloc_valid = 1'b0;
    bus.alloc_index = '0;
    bus.entry_valid = '0;
    bus.entry_ready = '0;
    bus.entry_fu    = '0;
    bus.mem_busy    = 1'b0;
    bus.flush       = 1'b0;
    bus.issue_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.issue_valid); end
    checks++; if (bus.issue_onehot !== 5'b0) begin errors++; $display("FAIL reset_onehot: got %b want 00000", bus.issue_onehot); end
    checks++; if (bus.issue_fu !== 2'b0) begin errors++; $display("FAIL reset_fu: got %b want 00", bus.issue_fu); end
    checks++; if (bus.issue_mult_unit !== 1'b0) begin errors++; $display("FAIL reset_unit: got %b want 0", bus.issue_mult_unit); end
    checks++; if (bus.free !== 5'b0) begin errors++; $display("FAIL reset_free: got %b want 00000", bus.free); end
    checks++; if (bus.mult_busy !== 2'b0) begin errors++; $display("FAIL reset_mult_busy: got %b want 00", bus.mult_busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_age_order();
    exp_t e;
    logic [N-1:0] exp_free;
    int first = -1;
    int last  = -1;
    alloc(2, ALU);
    alloc(0, ALU);
    alloc(4, ALU);
    exp_q.push_back('{oh: 5'b00100, fu: ALU, mu: 1'b0});
    exp_q.push_back('{oh: 5'b00001, fu: ALU, mu: 1'b0});
    exp_q.push_back('{oh: 5'b10000, fu: ALU, mu: 1'b0});
    bus.entry_ready = 5'b10101;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      tick();
      exp_free = '0;
      if (fired) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL age_extra: unexpected issue %b", fired_oh);
        end else begin
          e = exp_q.pop_front();
          exp_free = e.oh;
          if (first < 0) first = c;
          last = c;
          if ({fired_oh, fired_fu, fired_mu} !== {e.oh, e.fu, e.mu}) begin
            errors++; $display("FAIL age_issue: got %b/%0d/%0d want %b/%0d/%0d", fired_oh, fired_fu, fired_mu, e.oh, e.fu, e.mu);
          end
        end
      end
      checks++;
      if (bus.free !== exp_free) begin errors++; $display("FAIL age_free: got %b want %b", bus.free, exp_free); end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL age_timeout: %0d issues missing want 0", exp_q.size()); exp_q.delete(); end
    checks++; if (last - first != 2) begin errors++; $display("FAIL back_to_back: fire span %0d want 2", last - first); end
    bus.entry_ready = '0;
    tick();
    checks++; if (bus.free !== 5'b0) begin errors++; $display("FAIL age_free_end: got %b want 00000", bus.free); end
  endtask

  task automatic test_stall();
    exp_t e;
    alloc(1, ALU);
    exp_q.push_back('{oh: 5'b00010, fu: ALU, mu: 1'b0});
    bus.issue_ready = 1'b0;
    bus.entry_ready = 5'b00010;
    tick();
    checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("FAIL stall_present: got %b want 1", bus.issue_valid); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({bus.issue_valid, bus.issue_onehot, bus.free} !== {1'b1, 5'b00010, 5'b00000}) begin
        errors++; $display("FAIL stall_hold: valid=%b onehot=%b free=%b want 1/00010/00000", bus.issue_valid, bus.issue_onehot, bus.free);
      end
    end
    bus.issue_ready = 1'b1;
    tick();
    checks++;
    if (!fired || exp_q.size() == 0) begin
      errors++; $display("FAIL stall_fire: fired=%b want 1", fired);
    end else begin
      e = exp_q.pop_front();
      if (fired_oh !== e.oh) begin errors++; $display("FAIL stall_fire: got %b want %b", fired_oh, e.oh); end
      checks++; if (bus.free !== e.oh) begin errors++; $display("FAIL stall_free: got %b want %b", bus.free, e.oh); end
    end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL stall_drop: got %b want 0", bus.issue_valid); end
    bus.entry_ready = '0;
    tick();
    checks++; if (bus.free !== 5'b0) begin errors++; $display("FAIL stall_free_end: got %b want 00000", bus.free); end
  endtask

  task automatic test_mult_saturation();
    exp_t e;
    logic [N-1:0] exp_free;
    int c_f = -1;
    int c_l = -1;
    alloc(3, MULT);
    alloc(4, MULT);
    alloc(0, MULT);
    exp_q.push_back('{oh: 5'b01000, fu: MULT, mu: 1'b0});
    exp_q.push_back('{oh: 5'b10000, fu: MULT, mu: 1'b1});
    exp_q.push_back('{oh: 5'b00001, fu: MULT, mu: 1'b0});
    bus.entry_ready = 5'b11001;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      tick();
      exp_free = '0;
      if (fired) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL mult_extra: unexpected issue %b", fired_oh);
        end else begin
          e = exp_q.pop_front();
          exp_free = e.oh;
          if (e.oh == 5'b01000) c_f = c;
          if ({fired_oh, fired_fu, fired_mu} !== {e.oh, e.fu, e.mu}) begin
            errors++; $display("FAIL mult_issue: got %b/%0d/%0d want %b/%0d/%0d", fired_oh, fired_fu, fired_mu, e.oh, e.fu, e.mu);
          end
        end
      end
      if (c_l < 0 && bus.issue_valid === 1'b1 && bus.issue_onehot === 5'b00001) c_l = c;
      checks++;
      if (bus.free !== exp_free) begin errors++; $display("FAIL mult_free: got %b want %b", bus.free, exp_free); end
      if (c == 2) begin
        checks++; if (bus.mult_busy !== 2'b11) begin errors++; $display("FAIL mult_busy_full: got %b want 11", bus.mult_busy); end
      end
      if (c == 5) begin
        checks++; if (bus.mult_busy !== 2'b10) begin errors++; $display("FAIL mult_busy_release: got %b want 10", bus.mult_busy); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mult_timeout: %0d issues missing want 0", exp_q.size()); exp_q.delete(); end
    checks++; if (c_l - c_f != LAT + 1) begin errors++; $display("FAIL mult_reissue_gap: got %0d want %0d", c_l - c_f, LAT + 1); end
    bus.entry_ready = '0;
    for (int c = 0; c < LAT + 1; c++) tick();
    checks++; if (bus.mult_busy !== 2'b00) begin errors++; $display("FAIL mult_idle_end: got %b want 00", bus.mult_busy); end
  endtask

  task automatic test_mem_block();
    exp_t e;
    bus.mem_busy = 1'b1;
    alloc(2, LOAD);
    alloc(1, ALU);
    exp_q.push_back('{oh: 5'b00010, fu: ALU,  mu: 1'b0});
    exp_q.push_back('{oh: 5'b00100, fu: LOAD, mu: 1'b0});
    bus.entry_ready = 5'b00110;
    tick();
    tick();
    checks++;
    if (!fired || exp_q.size() == 0) begin
      errors++; $display("FAIL mem_alu_first: fired=%b want 1", fired);
    end else begin
      e = exp_q.pop_front();
      if ({fired_oh, fired_fu} !== {e.oh, e.fu}) begin errors++; $display("FAIL mem_alu_first: got %b/%0d want %b/%0d", fired_oh, fired_fu, e.oh, e.fu); end
    end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL mem_blocked: got valid %b want 0", bus.issue_valid); end
    bus.mem_busy = 1'b0;
    tick();
    checks++; if ({bus.issue_valid, bus.issue_onehot} !== {1'b1, 5'b00100}) begin errors++; $display("FAIL mem_load_next: got %b/%b want 1/00100", bus.issue_valid, bus.issue_onehot); end
    tick();
    checks++;
    if (!fired || exp_q.size() == 0) begin
      errors++; $display("FAIL mem_load_fire: fired=%b want 1", fired);
    end else begin
      e = exp_q.pop_front();
      if ({fired_oh, fired_fu} !== {e.oh, e.fu}) begin errors++; $display("FAIL mem_load_fire: got %b/%0d want %b/%0d", fired_oh, fired_fu, e.oh, e.fu); end
    end
    exp_q.delete();
    bus.entry_ready = '0;
    tick();
  endtask

  task automatic test_flush();
    exp_t e;
    logic [N-1:0] exp_free;
    alloc(3, MULT);
    bus.issue_ready = 1'b0;
    bus.entry_ready = 5'b01000;
    tick();
    checks++; if ({bus.issue_valid, bus.mult_busy} !== {1'b1, 2'b01}) begin errors++; $display("FAIL flush_setup: got %b/%b want 1/01", bus.issue_valid, bus.mult_busy); end
    bus.flush       = 1'b1;
    bus.issue_ready = 1'b1;
    tick();
    bus.flush       = 1'b0;
    bus.entry_valid = '0;
    bus.entry_ready = '0;
    checks++;
    if ({bus.issue_valid, bus.mult_busy, bus.free} !== {1'b0, 2'b00, 5'b00000}) begin
      errors++; $display("FAIL flush_clear: valid=%b busy=%b free=%b want 0/00/00000", bus.issue_valid, bus.mult_busy, bus.free);
    end
    tick();
    checks++; if (bus.free !== 5'b0) begin errors++; $display("FAIL flush_no_free: got %b want 00000", bus.free); end
    alloc(4, ALU);
    alloc(0, ALU);
    exp_q.push_back('{oh: 5'b10000, fu: ALU, mu: 1'b0});
    exp_q.push_back('{oh: 5'b00001, fu: ALU, mu: 1'b0});
    bus.entry_ready = 5'b10001;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      tick();
      exp_free = '0;
      if (fired) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL flush_extra: unexpected issue %b", fired_oh);
        end else begin
          e = exp_q.pop_front();
          exp_free = e.oh;
          if (fired_oh !== e.oh) begin errors++; $display("FAIL flush_order: got %b want %b", fired_oh, e.oh); end
        end
      end
      checks++;
      if (bus.free !== exp_free) begin errors++; $display("FAIL flush_free: got %b want %b", bus.free, exp_free); end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL flush_timeout: %0d issues missing want 0", exp_q.size()); exp_q.delete(); end
    bus.entry_ready = '0;
    tick();
  endtask

  task automatic test_async_reset();
    alloc(2, ALU);
    alloc(1, MULT);
    bus.entry_ready = 5'b00110;
    tick();
    tick();
    bus.issue_ready = 1'b0;
    checks++;
    if ({bus.free, bus.issue_fu, bus.mult_busy} !== {5'b00100, MULT, 2'b01}) begin
      errors++; $display("FAIL areset_setup: free=%b fu=%0d busy=%b want 00100/3/01", bus.free, bus.issue_fu, bus.mult_busy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.issue_valid, bus.issue_onehot, bus.issue_fu, bus.issue_mult_unit, bus.free, bus.mult_busy} !== 16'b0) begin
      errors++; $display("FAIL areset_clear: valid=%b onehot=%b fu=%b unit=%b free=%b busy=%b want all zero",
                         bus.issue_valid, bus.issue_onehot, bus.issue_fu, bus.issue_mult_unit, bus.free, bus.mult_busy);
    end
    bus.entry_valid = '0;
    bus.entry_ready = '0;
    bus.issue_ready = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_age_order();
    test_stall();
    test_mult_saturation();
    test_mem_block();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
